// File: rtl/sd_image_reader.sv
// sd_image_reader
//   Read-side sequencer for the SD card image path. When an image read is
//   requested, it issues one sector read per sector, walking consecutive
//   sector addresses from IMG_START_SEC. Each 16-bit read word is registered
//   and forwarded into the 16w/32r FIFO. A sector is only started when the
//   FIFO has room for a whole sector. Image completion is reported on
//   image_done_n.
//
// Ports
//   SD_clk_ref, sys_rst_n       clock, async active-low reset
//   sd_init_done                SD controller ready; gates requests
//   sys_image_read_req          request level; its rising edge is the request
//   rd_busy/rd_val_en/rd_val_data   controller read-port status and data
//   rd_start_en/rd_sec_addr     sector-read start pulse and address
//   fifo_wr_en/fifo_wr_data     FIFO write port
//   fifo_full/fifo_wr_len       FIFO status (write-side fill in words)
//   image_done_n                low once the last image is fully read
//   sec_cnt                     sectors completed in the current image
//   overflow_err/short_err      sticky error flags, cleared by reset only
//
// State | meaning
//   IDLE        | waiting for a request edge with the card initialised
//   WAIT_ROOM   | waiting for a sector's worth of FIFO space and idle controller
//   START       | one-cycle sector-read start pulse
//   WAIT_BUSY_H | waiting for the controller to accept the read (with timeout)
//   WAIT_BUSY_L | sector transfer in progress; words forwarded to the FIFO
//   DONE        | flag image completion, then back to IDLE

module sd_image_reader #(
  parameter logic [31:0] IMG_START_SEC = 32'd10000,
  parameter logic [15:0] IMG_SEC_NUM   = 16'd1200,
  parameter int          FIFO_DEPTH    = 2048,
  parameter int          LEN_W         = 11,
  parameter int          BUSY_TIMEOUT  = 1023
) (
  input  logic             SD_clk_ref,
  input  logic             sys_rst_n,
  input  logic             sd_init_done,
  input  logic             sys_image_read_req,
  input  logic             rd_busy,
  input  logic             rd_val_en,
  input  logic [15:0]      rd_val_data,
  output logic             rd_start_en,
  output logic [31:0]      rd_sec_addr,
  output logic             fifo_wr_en,
  output logic [15:0]      fifo_wr_data,
  input  logic             fifo_full,
  input  logic [LEN_W-1:0] fifo_wr_len,
  output logic             image_done_n,
  output logic [15:0]      sec_cnt,
  output logic             overflow_err,
  output logic             short_err
);

  localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  // Free space is computed one bit wider than the level so it cannot wrap.
  localparam logic [LEN_W:0] DEPTH_C  = (LEN_W+1)'(FIFO_DEPTH);
  localparam logic [LEN_W:0] SECTOR_W = (LEN_W+1)'(256);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROOM,
    START,
    WAIT_BUSY_H,
    WAIT_BUSY_L,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [15:0]      sec_idx_q, sec_idx_d;
  logic [15:0]      sec_cnt_q, sec_cnt_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             start_q, start_d;
  logic [31:0]      addr_q, addr_d;
  logic             wr_en_q, wr_en_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             done_n_q, done_n_d;
  logic             ovf_q, ovf_d;
  logic             short_q, short_d;

  logic [LEN_W:0]   free_room;
  logic             room_ok;
  logic             req_edge;

  assign free_room = DEPTH_C - {1'b0, fifo_wr_len};
  assign room_ok   = (free_room >= SECTOR_W) && !fifo_full && !rd_busy;
  assign req_edge  = sys_image_read_req && !req_q;

  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      sec_idx_q <= '0;
      sec_cnt_q <= '0;
      wcnt_q    <= '0;
      tmr_q     <= '0;
      start_q   <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_n_q  <= 1'b1;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sec_idx_q <= sec_idx_d;
      sec_cnt_q <= sec_cnt_d;
      wcnt_q    <= wcnt_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_n_q  <= done_n_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = sys_image_read_req;
    sec_idx_d = sec_idx_q;
    sec_cnt_d = sec_cnt_q;
    wcnt_d    = wcnt_q;
    tmr_d     = tmr_q;
    start_d   = 1'b0;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_n_d  = done_n_q;
    ovf_d     = ovf_q;
    short_d   = short_q;

    // Words are only accepted while a sector read is outstanding; a word
    // that finds the FIFO full is lost but still counted toward the sector.
    if ((state_q == WAIT_BUSY_H || state_q == WAIT_BUSY_L) && rd_val_en) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = rd_val_data;
      end
      if (wcnt_q != 9'd511) wcnt_d = wcnt_q + 9'd1;
    end

    case (state_q)
      IDLE: begin
        if (req_edge && sd_init_done) begin
          state_d   = WAIT_ROOM;
          sec_idx_d = '0;
          sec_cnt_d = '0;
          done_n_d  = 1'b1;
        end
      end
      WAIT_ROOM: begin
        if (room_ok) begin
          state_d = START;
          start_d = 1'b1;
          addr_d  = IMG_START_SEC + {16'd0, sec_idx_q};
        end
      end
      START: begin
        wcnt_d  = '0;
        tmr_d   = TMR_W'(BUSY_TIMEOUT - 1);
        state_d = WAIT_BUSY_H;
      end
      WAIT_BUSY_H: begin
        if (rd_busy) begin
          state_d = WAIT_BUSY_L;
        end else if (tmr_q == '0) begin
          state_d = WAIT_ROOM;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      WAIT_BUSY_L: begin
        if (!rd_busy) begin
          // Uses the post-increment count so a word on the final cycle counts.
          if (wcnt_d != 9'd256) short_d = 1'b1;
          sec_idx_d = sec_idx_q + 16'd1;
          sec_cnt_d = sec_cnt_q + 16'd1;
          state_d   = (sec_idx_d == IMG_SEC_NUM) ? DONE : WAIT_ROOM;
        end
      end
      DONE: begin
        done_n_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_start_en  = start_q;
  assign rd_sec_addr  = addr_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign image_done_n = done_n_q;
  assign sec_cnt      = sec_cnt_q;
  assign overflow_err = ovf_q;
  assign short_err    = short_q;

endmodule
